// File: rtl/complex_pkg.sv
// Shared constants and control-state encoding for the complex product
// multiplier / accumulator chain.
package complex_pkg;
  localparam int WIDTH_PR        = 15;
  localparam int ACC_LEN_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;
endpackage

// File: rtl/complex_acc_lane.sv
// One signed accumulator lane: the frame sum builds in acc_q and is copied to a
// held output register on dump, which also clears the running sum.
module complex_acc_lane
  import complex_pkg::*;
#(
  parameter int WIDTH_IN  = WIDTH_PR,
  parameter int WIDTH_OUT = WIDTH_PR + 4
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic                        clr_in,
  input  logic                        add_in,
  input  logic                        dump_in,
  input  logic signed [WIDTH_IN-1:0]  d_in,
  output logic signed [WIDTH_OUT-1:0] sum_out
);

  logic signed [WIDTH_OUT-1:0] ext;
  logic signed [WIDTH_OUT-1:0] base;
  logic signed [WIDTH_OUT-1:0] addend;
  logic signed [WIDTH_OUT-1:0] acc_q, acc_d;
  logic signed [WIDTH_OUT-1:0] sum_q, sum_d;

  assign ext = {{(WIDTH_OUT-WIDTH_IN){d_in[WIDTH_IN-1]}}, d_in};

  always_comb begin
    base   = clr_in ? '0 : acc_q;
    addend = add_in ? ext : '0;
    acc_d  = base + addend;
    sum_d  = sum_q;
    // The last sample is folded straight into the dumped sum.
    if (dump_in) begin
      sum_d = acc_q + ext;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/complex_accumulator.sv
// Frame accumulator for the complex product stream: sums ACC_LEN valid products
// per frame and emits the complex sum as a one-cycle result.
module complex_accumulator
  import complex_pkg::*;
#(
  parameter int WIDTH_IN  = WIDTH_PR,
  parameter int ACC_LEN   = ACC_LEN_DEFAULT,
  parameter int WIDTH_OUT = WIDTH_IN + $clog2(ACC_LEN)
) (
  input  logic                         clk,
  input  logic                         reset_in,
  input  logic                         ce_in,
  input  logic                         start_in,
  input  logic                         continuous_in,
  input  logic                         valid_in,
  input  logic signed [WIDTH_IN-1:0]   pr_in,
  input  logic signed [WIDTH_IN-1:0]   pi_in,
  output logic signed [WIDTH_OUT-1:0]  sr_out,
  output logic signed [WIDTH_OUT-1:0]  si_out,
  output logic                         valid_out,
  output logic [$clog2(ACC_LEN)-1:0]   count_out,
  output logic                         busy_out
);

  localparam int CW = $clog2(ACC_LEN);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  acc_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          clr, add, dump;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    clr     = 1'b0;
    add     = 1'b0;
    dump    = 1'b0;
    if (ce_in) begin
      // Start wins over everything, including a last-sample cycle.
      if (start_in) begin
        state_d = ACC;
        clr     = 1'b1;
        add     = valid_in;
        cnt_d   = valid_in ? CW'(1) : '0;
      end else if (state_q == ACC && valid_in) begin
        if (cnt_q == LAST) begin
          dump    = 1'b1;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = continuous_in ? ACC : IDLE;
        end else begin
          add   = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  complex_acc_lane #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) u_lane_re (
    .clk      (clk),
    .reset_in (reset_in),
    .clr_in   (clr),
    .add_in   (add),
    .dump_in  (dump),
    .d_in     (pr_in),
    .sum_out  (sr_out)
  );

  complex_acc_lane #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) u_lane_im (
    .clk      (clk),
    .reset_in (reset_in),
    .clr_in   (clr),
    .add_in   (add),
    .dump_in  (dump),
    .d_in     (pi_in),
    .sum_out  (si_out)
  );

  assign valid_out = valid_q & ce_in;
  assign count_out = cnt_q;
  assign busy_out  = (state_q == ACC);

endmodule

// File: tb/tb_complex_accumulator.sv
// Directed and randomized bench for complex_accumulator with ACC_LEN = 4,
// checked against a frame-queue reference model.
module tb_complex_accumulator;
  localparam int WI = 15;
  localparam int AL = 4;
  localparam int WO = WI + $clog2(AL);

  logic                 clk = 1'b0;
  logic                 reset_in;
  logic                 ce_in, start_in, continuous_in, valid_in;
  logic signed [WI-1:0] pr_in, pi_in;
  logic signed [WO-1:0] sr_out, si_out;
  logic                 valid_out;
  logic [$clog2(AL)-1:0] count_out;
  logic                 busy_out;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  bit m_busy;
  int m_re[$];
  int m_im[$];
  int m_sr, m_si;
  bit m_vout;
  int dump_cycles[$];

  complex_accumulator #(.WIDTH_IN(WI), .ACC_LEN(AL), .WIDTH_OUT(WO)) dut (
    .clk           (clk),
    .reset_in      (reset_in),
    .ce_in         (ce_in),
    .start_in      (start_in),
    .continuous_in (continuous_in),
    .valid_in      (valid_in),
    .pr_in         (pr_in),
    .pi_in         (pi_in),
    .sr_out        (sr_out),
    .si_out        (si_out),
    .valid_out     (valid_out),
    .count_out     (count_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_re.delete();
    m_im.delete();
    m_sr = 0;
    m_si = 0;
    m_vout = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic signed [31:0] sr_x, si_x;
    sr_x = sr_out;
    si_x = si_out;
    check({tag, "_vout"},  {31'd0, valid_out}, {31'd0, m_vout});
    check({tag, "_count"}, {30'd0, count_out}, m_re.size());
    check({tag, "_busy"},  {31'd0, busy_out},  {31'd0, m_busy});
    check({tag, "_sr"},    sr_x, m_sr);
    check({tag, "_si"},    si_x, m_si);
  endtask

  // One clock: drive inputs, advance the model from the frame rules, compare.
  task automatic step(input string tag, input bit ce, input bit st, input bit cont,
                      input bit v, input int pr, input int pi);
    int s_r, s_i;
    ce_in = ce; start_in = st; continuous_in = cont; valid_in = v;
    pr_in = WI'(pr); pi_in = WI'(pi);
    @(posedge clk);
    #1;
    cyc++;
    m_vout = 1'b0;
    if (ce) begin
      if (st) begin
        m_busy = 1'b1;
        m_re.delete();
        m_im.delete();
        if (v) begin
          m_re.push_back(pr);
          m_im.push_back(pi);
        end
      end else if (m_busy && v) begin
        m_re.push_back(pr);
        m_im.push_back(pi);
        if (m_re.size() == AL) begin
          s_r = 0;
          s_i = 0;
          foreach (m_re[k]) begin
            s_r += m_re[k];
            s_i += m_im[k];
          end
          m_sr = s_r;
          m_si = s_i;
          m_vout = 1'b1;
          m_re.delete();
          m_im.delete();
          m_busy = cont;
        end
      end
    end
    if (valid_out) dump_cycles.push_back(cyc);
    check_all(tag);
  endtask

  initial begin
    logic signed [31:0] tmp;
    reset_in = 1'b1;
    ce_in = 1'b0; start_in = 1'b0; continuous_in = 1'b0; valid_in = 1'b0;
    pr_in = '0; pi_in = '0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset_in = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: four (4,0) samples, single shot
    step("t1_start", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t1_s", 1, 0, 0, 1, 4, 0);
    tmp = sr_out;
    check("t1_sr16", tmp, 16);
    check("t1_vout", {31'd0, valid_out}, 1);
    step("t1_after", 1, 0, 0, 0, 0, 0);
    check("t1_idle", {31'd0, busy_out}, 0);

    // Test 2: mixed-sign samples
    step("t2_start", 1, 1, 0, 0, 0, 0);
    step("t2_s0", 1, 0, 0, 1, -1000, 1000);
    step("t2_s1", 1, 0, 0, 1, 1100, -800);
    step("t2_s2", 1, 0, 0, 1, -500, 200);
    step("t2_s3", 1, 0, 0, 1, 500, 300);
    tmp = sr_out; check("t2_sr100", tmp, 100);
    tmp = si_out; check("t2_si700", tmp, 700);

    // Test 3: continuous full-scale, two dumps 4 cycles apart
    dump_cycles.delete();
    step("t3_start", 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step("t3_s", 1, 0, 1, 1, 16383, -16384);
      if (valid_out) begin
        tmp = sr_out; check("t3_sr", tmp, 65532);
        tmp = si_out; check("t3_si", tmp, -65536);
      end
    end
    check("t3_ndump", dump_cycles.size(), 2);
    if (dump_cycles.size() == 2)
      check("t3_spacing", dump_cycles[1] - dump_cycles[0], 4);
    check("t3_busy", {31'd0, busy_out}, 1);

    // Test 4: valid gaps and ce low mid-frame
    step("t4_start", 1, 1, 0, 0, 0, 0);
    step("t4_s0", 1, 0, 0, 1, 1, 1);
    step("t4_gap", 1, 0, 0, 0, 9, 9);
    step("t4_s1", 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step("t4_ce0", 0, 0, 0, 1, 50, 50);
      check("t4_hold", {30'd0, count_out}, 2);
    end
    step("t4_s2", 1, 0, 0, 1, 1, 1);
    step("t4_gap2", 1, 0, 0, 0, 3, 3);
    step("t4_s3", 1, 0, 0, 1, 1, 1);
    tmp = sr_out; check("t4_sr4", tmp, 4);
    tmp = si_out; check("t4_si4", tmp, 4);

    // Test 5: restart mid-frame, then start on the last sample
    step("t5_start", 1, 1, 0, 0, 0, 0);
    step("t5_a0", 1, 0, 0, 1, 7, 7);
    step("t5_a1", 1, 0, 0, 1, 7, 7);
    step("t5_restart", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t5_b", 1, 0, 0, 1, 1, -1);
    tmp = sr_out; check("t5_sr4", tmp, 4);
    tmp = si_out; check("t5_sim4", tmp, -4);
    step("t5_start2", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t5_c", 1, 0, 0, 1, 2, 2);
    step("t5_stlast", 1, 1, 0, 1, 5, 6);
    check("t5_nodump", {31'd0, valid_out}, 0);
    check("t5_cnt1", {30'd0, count_out}, 1);

    // Test 6: asynchronous reset mid-frame
    step("t6_s", 1, 0, 0, 1, 3, 3);
    #2;
    reset_in = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    @(negedge clk);
    reset_in = 1'b0;
    step("t6_ignored", 1, 0, 0, 1, 8, 8);
    step("t6_ignored2", 1, 0, 1, 1, 8, 8);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7,
           int'($urandom_range(0, 32767)) - 16384,
           int'($urandom_range(0, 32767)) - 16384);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_accumulator.md
# complex_accumulator

Downstream stage of `complex_multiplier`. It consumes the multiplier's registered complex product stream (`pr_out`/`pi_out`) and accumulates a programmable number of valid products per frame. At the end of each frame it emits the complex sum as a one-cycle result, which forms a correlator / dot-product back end. Supports single-shot and continuous back-to-back frames, with no sample loss at frame boundaries.

## Interface
- `WIDTH_IN`, 15: signed width of each product component; matches the multiplier `width_PR`.
- `ACC_LEN`, 16: valid samples per frame; must be ≥ 2 and a power of two.
- `WIDTH_OUT`, `WIDTH_IN + $clog2(ACC_LEN)`: signed width of the sums; guarantees no overflow.

Ports:
- `clk` in 1: the only clock; all logic is on the rising edge.
- `reset_in` in 1: asynchronous, active-high reset.
- `ce_in` in 1: clock enable. When low, all state holds and `valid_out` is forced to 0.
- `start_in` in 1: synchronous frame start or restart.
- `continuous_in` in 1: 1 = re-arm automatically after each dump; 0 = return to IDLE.
- `valid_in` in 1: `pr_in`/`pi_in` carry a product this cycle.
- `pr_in` in `WIDTH_IN`: real part of the product, two's complement.
- `pi_in` in `WIDTH_IN`: imaginary part of the product, two's complement.
- `sr_out` out `WIDTH_OUT`: real frame sum, held until the next dump.
- `si_out` out `WIDTH_OUT`: imaginary frame sum, held until the next dump.
- `valid_out` out 1: one-cycle pulse; `sr_out`/`si_out` are new.
- `count_out` out `$clog2(ACC_LEN)`: number of samples accumulated in the current frame.
- `busy_out` out 1: high in ACC state.

## Operation
- States: IDLE and ACC.
  - IDLE: `valid_in` is ignored; `start_in` moves to ACC.
  - ACC: every cycle with `ce_in && valid_in` adds the sign-extended inputs to the accumulators and increments the count.
- Last sample (count == `ACC_LEN-1` with `valid_in`):
  - `sr_out` ← `acc_r + pr_in` and `si_out` ← `acc_i + pi_in`.
  - `valid_out` is set; accumulators and count clear.
  - Next state is ACC if `continuous_in` = 1, otherwise IDLE.
- `start_in` in ACC aborts the frame: accumulators and count clear, no `valid_out`, state stays ACC.
  - If `valid_in` is high in the same cycle, that sample becomes sample 0 of the new frame.
  - This also applies in IDLE: a `start_in` + `valid_in` cycle captures the sample.
- `start_in` on the last-sample cycle: `start_in` wins. The frame is discarded, no dump occurs, and the sample starts the new frame.
- Arithmetic: inputs are sign-extended to `WIDTH_OUT`. The sum of `ACC_LEN` values of `WIDTH_IN` bits cannot overflow, so there is no saturation and no wrap check.
- `ce_in` low: state, count, accumulators and outputs all hold; the `valid_in` sample is dropped and `valid_out` reads 0.

## Timing
- Reset values: `sr_out` = 0, `si_out` = 0, `valid_out` = 0, `count_out` = 0, `busy_out` = 0, state = IDLE. Reset takes effect immediately and asynchronously, including mid-frame; the partial sum is lost.
- Latency is 1 clock: the edge that captures the last sample also registers the sums and raises `valid_out` for exactly one cycle.
- Frames run back-to-back in continuous mode: sample 0 of frame n+1 can arrive on the cycle immediately after the last sample of frame n, with no gap.
- `count_out` and `busy_out` are registered and reflect the state after the current edge.

## Structure
- Shared package `complex_pkg`: width constants `WIDTH_PR` = 15 and `ACC_LEN_DEFAULT` = 16, plus the state enum `acc_state_t {IDLE, ACC}`.
- Sub-module `complex_acc_lane`: a single signed accumulator with clear/add/dump controls, instantiated twice (real and imaginary).
- Control FSM and counter live in the top level.

## Test plan
Use `ACC_LEN` = 4 throughout.
1. Reset, then `start_in`, then 4 valid samples of (4, 0) → `valid_out` pulses 1 cycle after the 4th sample with `sr_out` = 16 and `si_out` = 0. `busy_out` is 0 afterwards (`continuous_in` = 0).
2. Samples (-1000, 1000), (1100, -800), (-500, 200), (500, 300) → `sr_out` = 100, `si_out` = 700. Checks sign extension and negative partial sums.
3. `continuous_in` = 1 with 8 consecutive valid samples of (16383, -16384), i.e. full-scale → two `valid_out` pulses exactly 4 cycles apart. Each gives `sr_out` = 65532 and `si_out` = -65536, with no overflow.
4. `valid_in` gaps plus `ce_in` low for 3 cycles mid-frame, with samples (1, 1) → `count_out` holds during the gaps. Samples presented while `ce_in` is low are dropped, and the result is still (4, 4).
5. `start_in` after 2 samples of (7, 7), then 4 samples of (1, -1) → a single dump of (4, -4). Also `start_in` together with the last sample → no dump in that cycle.
6. Assert `reset_in` asynchronously mid-frame → all outputs read 0 immediately and state is IDLE. `valid_in` is ignored until the next `start_in`.
